// File: rtl/regfile_p_pkg.sv
// Shared definitions for the regfile_p register file.
// Holds the clear-sequencer state encoding and the default parameter values
// used by regfile_p and regfile_clr_seq.
package regfile_p_pkg;

  // Clear-sequencer states: IDLE accepts port writes, CLEAR sweeps the array.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_SP_IDX  = 14;
  localparam int DEF_ZERO_R0 = 0;

endpackage : regfile_p_pkg

// File: rtl/regfile_clr_seq.sv
// Clear sequencer for regfile_p.
// On a clr request in IDLE it walks an index counter from 0 to NREGS-1, one
// register per cycle, then returns to IDLE. clr requests during a sweep are
// ignored.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (forces IDLE, counter 0)
//   clr      request to start a sweep (sampled in IDLE only)
//   busy     high while a sweep is in progress
//   clr_en   strobe: zero register clr_idx on the next edge
//   clr_idx  index of the register being cleared this cycle
module regfile_clr_seq
  import regfile_p_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr) state_nxt = CLEAR;
      end
      CLEAR: begin
        // The counter wraps naturally from all-ones back to zero, which
        // leaves it ready for the next sweep.
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy    = (state == CLEAR);
  assign clr_en  = busy;
  assign clr_idx = cnt;

endmodule : regfile_clr_seq

// File: rtl/regfile_p.sv
// Multi-ported register file with write-to-read bypass, an exported
// stack-pointer register and a background clear sweep.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; zeroes every register
//   we/wa/wd  write enable, index and data (ignored while busy or in reset)
//   ra1/rd1   read port 1 index / combinational data
//   ra2/rd2   read port 2 index / combinational data
//   rsp       stored contents of register SP_IDX (no bypass)
//   clr       request a clear sweep of the whole array
//   busy      high while the clear sweep runs
module regfile_p
  import regfile_p_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SP_IDX  = DEF_SP_IDX,
  parameter int ZERO_R0 = DEF_ZERO_R0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rsp,
  input  logic              clr,
  output logic              busy
);

  localparam int                NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_A  = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_acc;
  logic              wa_zero, ra1_zero, ra2_zero;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // Register 0 is hardwired to zero only in the ZERO_R0 configuration.
  assign wa_zero  = (ZERO_R0 != 0) && (wa  == '0);
  assign ra1_zero = (ZERO_R0 != 0) && (ra1 == '0);
  assign ra2_zero = (ZERO_R0 != 0) && (ra2 == '0);

  // A port write lands only in IDLE and outside reset; the same term gates
  // the bypass, so reads never forward data that will not be stored.
  assign wr_acc = we && !busy && !rst && !wa_zero;

  // NOTE: the array is reset because a clean all-zero state after reset is
  // part of this block's contract; storage without that need would be left
  // unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // Port writes and sweep clears are mutually exclusive because wr_acc
      // is blocked while busy.
      if (wr_acc) regs[wa]      <= wd;
      if (clr_en) regs[clr_idx] <= '0;
    end
  end

  assign rd1 = ra1_zero                  ? '0 :
               (wr_acc && (wa == ra1))   ? wd : regs[ra1];
  assign rd2 = ra2_zero                  ? '0 :
               (wr_acc && (wa == ra2))   ? wd : regs[ra2];

  assign rsp = regs[SP_A];

endmodule : regfile_p

// File: tb/tb_regfile_p.sv
// Self-checking bench for regfile_p: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_p;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int SP = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, clr;
  logic [AW-1:0] wa, ra1, ra2;
  logic [DW-1:0] wd, rd1, rd2, rsp;
  logic          busy;

  logic          z_we, z_clr;
  logic [AW-1:0] z_wa, z_ra1, z_ra2;
  logic [DW-1:0] z_wd, z_rd1, z_rd2, z_rsp;
  logic          z_busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [NR];
  logic          model_busy;

  always #5 clk = ~clk;

  regfile_p #(.DATA_W(DW), .ADDR_W(AW), .SP_IDX(SP), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .rsp(rsp), .clr(clr), .busy(busy)
  );

  regfile_p #(.DATA_W(DW), .ADDR_W(AW), .SP_IDX(SP), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .we(z_we), .wa(z_wa), .wd(z_wd), .ra1(z_ra1), .ra2(z_ra2),
    .rd1(z_rd1), .rd2(z_rd2), .rsp(z_rsp), .clr(z_clr), .busy(z_busy)
  );

  // Expected read value: an accepted write (not busy, not in reset) to the
  // same index forwards its data, otherwise the stored contents.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (we && !model_busy && !rst && (wa == ra)) return wd;
    return mem[ra];
  endfunction

  task automatic model_zero();
    for (int i = 0; i < NR; i++) mem[i] = '0;
  endtask

  // Walks every index on both ports, one cycle per index (we/clr must be low).
  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      @(posedge clk); #1;
      ra1 = AW'(i);
      ra2 = AW'(NR - 1 - i);
      @(negedge clk);
      checks++;
      if (rd1 !== mem[i]) begin
        errors++;
        $display("FAIL %s rd1[%0d]: got %h exp %h", tag, i, rd1, mem[i]);
      end
      checks++;
      if (rd2 !== mem[NR-1-i]) begin
        errors++;
        $display("FAIL %s rd2[%0d]: got %h exp %h", tag, NR-1-i, rd2, mem[NR-1-i]);
      end
    end
  endtask

  task automatic fill_all();
    for (int i = 0; i < NR; i++) begin
      @(posedge clk); #1;
      we = 1'b1;
      wa = AW'(i);
      wd = $urandom;
      @(posedge clk); #1;
      mem[i] = wd;
      we = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    we = 1'b0; clr = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    z_we = 1'b0; z_clr = 1'b0; z_wa = '0; z_wd = '0; z_ra1 = '0; z_ra2 = '0;
    model_busy = 1'b0;
    model_zero();
    #2;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b exp 0", busy);
    end
    checks++;
    if (rsp !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got %h exp 0", rsp);
    end
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b exp 0", busy);
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    we = 1'b1; wa = 4'd3; wd = 32'h0000_00AA;
    @(posedge clk); #1;
    mem[3] = wd;
    we = 1'b0;
    ra1 = 4'd3;
    @(negedge clk);
    checks++;
    if (rd1 !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL write_read_r3: got %h exp 000000aa", rd1);
    end
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    we = 1'b1; wa = 4'd5; wd = 32'h1234_5678; ra1 = 4'd5; ra2 = 4'd5;
    @(negedge clk);
    checks++;
    if (rd1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bypass_rd1: got %h exp 12345678", rd1);
    end
    checks++;
    if (rd2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bypass_rd2: got %h exp 12345678", rd2);
    end
    @(posedge clk); #1;
    mem[5] = wd;
    we = 1'b0;
    @(negedge clk);
    checks++;
    if (rd1 !== 32'h1234_5678 || rd2 !== rd1) begin
      errors++;
      $display("FAIL bypass_stored: got %h/%h exp 12345678", rd1, rd2);
    end
  endtask

  task automatic test_rsp();
    @(posedge clk); #1;
    we = 1'b1; wa = AW'(SP); wd = 32'h0000_1000;
    @(negedge clk);
    checks++;
    if (rsp !== mem[SP]) begin
      errors++;
      $display("FAIL rsp_write_cycle: got %h exp %h", rsp, mem[SP]);
    end
    @(posedge clk); #1;
    mem[SP] = wd;
    we = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp !== 32'h0000_1000) begin
      errors++;
      $display("FAIL rsp_after_edge: got %h exp 00001000", rsp);
    end
  endtask

  task automatic test_zero_r0();
    @(posedge clk); #1;
    z_we = 1'b1; z_wa = '0; z_wd = 32'hFFFF_FFFF; z_ra1 = '0; z_ra2 = '0;
    @(negedge clk);
    checks++;
    if (z_rd1 !== '0 || z_rd2 !== '0) begin
      errors++;
      $display("FAIL zero_r0_bypass: got %h/%h exp 0", z_rd1, z_rd2);
    end
    @(posedge clk); #1;
    z_wa = 4'd7; z_wd = 32'hCAFE_0007; z_ra2 = 4'd7;
    @(negedge clk);
    checks++;
    if (z_rd1 !== '0) begin
      errors++;
      $display("FAIL zero_r0_stored: got %h exp 0", z_rd1);
    end
    checks++;
    if (z_rd2 !== 32'hCAFE_0007) begin
      errors++;
      $display("FAIL zero_r0_other_bypass: got %h exp cafe0007", z_rd2);
    end
    @(posedge clk); #1;
    z_we = 1'b0;
    @(negedge clk);
    checks++;
    if (z_rd2 !== 32'hCAFE_0007 || z_rd1 !== '0) begin
      errors++;
      $display("FAIL zero_r0_after: got %h/%h exp 0/cafe0007", z_rd1, z_rd2);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e1, e2;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      we  = ($urandom_range(0, 2) != 0);
      wa  = AW'($urandom_range(0, NR - 1));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
      @(negedge clk);
      e1 = exp_rd(ra1);
      e2 = exp_rd(ra2);
      checks++;
      if (rd1 !== e1) begin
        errors++;
        $display("FAIL rand_rd1 c=%0d ra1=%0d: got %h exp %h", c, ra1, rd1, e1);
      end
      checks++;
      if (rd2 !== e2) begin
        errors++;
        $display("FAIL rand_rd2 c=%0d ra2=%0d: got %h exp %h", c, ra2, rd2, e2);
      end
      checks++;
      if (rsp !== mem[SP] || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_rsp c=%0d: got %h busy %b exp %h busy 0", c, rsp, busy, mem[SP]);
      end
      @(posedge clk);
      if (we) mem[wa] = wd;
    end
    #1;
    we = 1'b0;
  endtask

  task automatic test_clear_sweep();
    int pos;
    int busy_cnt;
    logic [DW-1:0] e1, e2;
    fill_all();
    @(posedge clk); #1;
    clr = 1'b1; we = 1'b1; wa = 4'd2; wd = 32'h0000_0055; ra1 = 4'd2;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_busy_before: got %b exp 0", busy);
    end
    checks++;
    if (rd1 !== 32'h0000_0055) begin
      errors++;
      $display("FAIL sweep_start_bypass: got %h exp 00000055", rd1);
    end
    @(posedge clk); #1;
    mem[2] = wd;
    clr = 1'b0;
    model_busy = 1'b1;
    pos = 0;
    busy_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      clr = (c >= 5 && c <= 7);
      if (!model_busy) we = 1'b0;
      ra1 = AW'($urandom_range(0, NR - 1));
      ra2 = 4'd2;
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (busy !== model_busy) begin
        errors++;
        $display("FAIL sweep_busy c=%0d: got %b exp %b", c, busy, model_busy);
      end
      e1 = exp_rd(ra1);
      e2 = exp_rd(ra2);
      checks++;
      if (rd1 !== e1 || rd2 !== e2) begin
        errors++;
        $display("FAIL sweep_read c=%0d ra1=%0d: got %h/%h exp %h/%h", c, ra1, rd1, rd2, e1, e2);
      end
      @(posedge clk); #1;
      if (model_busy) begin
        mem[pos] = '0;
        pos++;
        if (pos == NR) model_busy = 1'b0;
      end
    end
    clr = 1'b0;
    we = 1'b0;
    checks++;
    if (busy_cnt != NR) begin
      errors++;
      $display("FAIL sweep_length: got %0d exp %0d", busy_cnt, NR);
    end
    check_all("after_sweep");
  endtask

  task automatic test_rst_mid_sweep();
    fill_all();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_busy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      mem[k] = '0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_sweep_busy_pre: got %b exp 1", busy);
    end
    rst = 1'b1;
    we = 1'b1; wa = 4'd9; wd = 32'hDEAD_BEEF; ra1 = 4'd9; ra2 = 4'd12;
    model_busy = 1'b0;
    model_zero();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_sweep_busy: got %b exp 0", busy);
    end
    checks++;
    if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2) || rsp !== '0) begin
      errors++;
      $display("FAIL rst_sweep_zero: got %h/%h rsp %h exp 0", rd1, rd2, rsp);
    end
    @(posedge clk); #1;
    we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd1 !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_write: got %h busy %b exp 0 busy 0", rd1, busy);
    end
    check_all("after_rst");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_after: got %b exp 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_rsp();
    test_zero_r0();
    test_random();
    test_clear_sweep();
    test_rst_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_p
